// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and FSM state type for the UART transmit path.
package uart_tx_fifo_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

endpackage

// File: rtl/uart_tx_fifo_regfile.sv
// FIFO storage: NB_DATA x 2**ADDR_W register array, synchronous write, asynchronous read.
module fifo_regfile
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [NB_DATA-1:0] rdata
);

    logic [NB_DATA-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART transmitter one byte per tx_start/tx_done_tick handshake.
// Optional sticky overflow flag with ovf_clr when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [NB_DATA-1:0] wr_data,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W:0]    count,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    input  logic               tx_done_tick,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic               ovf_clr,
    output logic               overflow,
`endif
    output logic               busy
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [NB_DATA-1:0]  rd_data;
    logic                push;
    logic                pop;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign busy  = (state == BUSY);
    assign push  = wr_en && !full;
    // The slot is released on the transmitter's acknowledge, not on tx_start.
    assign pop   = (state == BUSY) && tx_done_tick;

    fifo_regfile #(
        .NB_DATA (NB_DATA),
        .ADDR_W  (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        tx_data  <= rd_data;
                        tx_start <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    tx_start <= 1'b0;
                    if (tx_done_tick)
                        state <= IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // A dropped push in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (optionally with UART_TX_FIFO_OVF_EN).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       full, empty, tx_start, busy;
    logic [4:0] count;
    logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       overflow;
`endif

    int tests = 0;
    int fails = 0;
    int starts = 0;
    int acked = 0;
    logic [7:0] txq[$];

    uart_tx_fifo #(
        .NB_DATA (8),
        .ADDR_W  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_clr      (ovf_clr),
        .overflow     (overflow),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Record every start pulse and the byte handed over with it.
    always @(negedge clk) begin
        if (reset && tx_start) begin
            starts++;
            txq.push_back(tx_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for the next unacknowledged start, then acknowledge after delay cycles.
    task automatic ack_next(input int delay);
        int t = 0;
        while (starts <= acked && t < 200) begin
            tick();
            t++;
        end
        tests++;
        if (starts <= acked) begin
            fails++;
            $display("FAIL ack_wait: no tx_start within 200 cycles (starts=%0d acked=%0d)", starts, acked);
        end else begin
            acked++;
            repeat (delay) tick();
            tx_done_tick = 1'b1;
            tick();
            tx_done_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        repeat (2) tick();
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", full); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
`ifdef UART_TX_FIFO_OVF_EN
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
        reset = 1'b1;
        repeat (2) tick();
        acked = starts;
    endtask

    task automatic test_single();
        int base = starts;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL single_count_push got=%0d exp=1", count); end
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_early_start got=%b exp=0", tx_start); end
        tick();
        tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_start got=%b exp=1", tx_start); end
        tests++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", tx_data); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick();
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width got=%b exp=0", tx_start); end
        repeat (3) tick();
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL single_count_hold got=%0d exp=1", count); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_hold got=%b exp=1", busy); end
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL single_count_pop got=%0d exp=0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty got=%b exp=1", empty); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        // Spurious tick in IDLE must not change anything.
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        repeat (3) tick();
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL single_spurious_count got=%0d exp=0", count); end
        tests++; if (starts - base !== 1) begin fails++; $display("FAIL single_pulses got=%0d exp=1", starts - base); end
        acked = starts;
    endtask

    task automatic test_burst();
        int base = starts;
        int qb = txq.size();
        acked = starts;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) ack_next(10);
        repeat (4) tick();
        tests++; if (starts - base !== 5) begin fails++; $display("FAIL burst_pulses got=%0d exp=5", starts - base); end
        tests++;
        if (txq.size() != qb + 5) begin
            fails++; $display("FAIL burst_qsize got=%0d exp=%0d", txq.size(), qb + 5);
        end else begin
            for (int i = 0; i < 5; i++)
                if (txq[qb+i] !== 8'(i + 1)) begin
                    fails++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, txq[qb+i], 8'(i + 1));
                end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL burst_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        int base = starts;
        int qb = txq.size();
        acked = starts;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL full_count got=%0d exp=16", count); end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag got=%b exp=1", full); end
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL full_drop_count got=%0d exp=16", count); end
`ifdef UART_TX_FIFO_OVF_EN
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        repeat (2) tick();
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        wr_en = 1'b1; wr_data = 8'hFF; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
`endif
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy got=%b exp=1", busy); end
        // Push against a full FIFO in the same cycle as the acknowledge: push is dropped.
        wr_en = 1'b1; wr_data = 8'hEE; tx_done_tick = 1'b1;
        tick();
        wr_en = 1'b0; tx_done_tick = 1'b0;
        acked = base + 1;
        tests++; if (count !== 5'd15) begin fails++; $display("FAIL full_pushpop_count got=%0d exp=15", count); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL full_pushpop_full got=%b exp=0", full); end
        for (int i = 0; i < 15; i++) ack_next(2);
        repeat (3) tick();
        tests++; if (starts - base !== 16) begin fails++; $display("FAIL full_pulses got=%0d exp=16", starts - base); end
        tests++;
        if (txq.size() != qb + 16) begin
            fails++; $display("FAIL full_qsize got=%0d exp=%0d", txq.size(), qb + 16);
        end else begin
            for (int i = 0; i < 16; i++)
                if (txq[qb+i] !== 8'(8'h10 + i)) begin
                    fails++; $display("FAIL full_data[%0d] got=%h exp=%h", i, txq[qb+i], 8'(8'h10 + i));
                end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_empty got=%b exp=1", empty); end
    endtask

    task automatic test_wrap();
        int qb = txq.size();
        int base = starts;
        acked = starts;
        fork
            begin
                int i = 0;
                int guard = 0;
                while (i < 40 && guard < 5000) begin
                    logic acc;
                    wr_en = ($urandom_range(0, 1) == 1);
                    wr_data = 8'(i);
                    acc = wr_en && !full;
                    tick();
                    if (acc) i++;
                    guard++;
                end
                wr_en = 1'b0;
            end
            begin
                for (int k = 0; k < 40; k++) ack_next(int'($urandom_range(0, 5)));
            end
        join
        repeat (4) tick();
        tests++; if (starts - base !== 40) begin fails++; $display("FAIL wrap_pulses got=%0d exp=40", starts - base); end
        tests++;
        if (txq.size() != qb + 40) begin
            fails++; $display("FAIL wrap_qsize got=%0d exp=%0d", txq.size(), qb + 40);
        end else begin
            for (int i = 0; i < 40; i++)
                if (txq[qb+i] !== 8'(i)) begin
                    fails++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, txq[qb+i], 8'(i));
                end
        end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL wrap_count got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        int s0;
        wr_en = 1'b1; wr_data = 8'hAA; tick();
        wr_data = 8'hBB; tick();
        wr_data = 8'hCC; tick();
        wr_en = 1'b0;
        tests++; if (count !== 5'd3) begin fails++; $display("FAIL rm_pre_count got=%0d exp=3", count); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rm_pre_busy got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rm_tx_start got=%b exp=0", tx_start); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got=%b exp=0", busy); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL rm_count got=%0d exp=0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rm_empty got=%b exp=1", empty); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rm_tx_data got=%h exp=00", tx_data); end
        tick();
        reset = 1'b1;
        s0 = starts;
        repeat (6) tick();
        tests++; if (starts !== s0) begin fails++; $display("FAIL rm_no_start got=%0d exp=%0d", starts, s0); end
        acked = starts;
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        ack_next(1);
        tick();
        tests++;
        if (txq.size() == 0) begin
            fails++; $display("FAIL rm_after_data got=none exp=5a");
        end else if (txq[txq.size()-1] !== 8'h5A) begin
            fails++; $display("FAIL rm_after_data got=%h exp=5a", txq[txq.size()-1]);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rm_after_empty got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
